// File: rtl/irq_ctrl.sv
// irq_ctrl: priority interrupt controller in front of the MCU core.
// Latches rising edges on the request lines and applies a software mask.
// Presents one source at a time as interrupt/irq, then tracks ack and eoi.
// Optional macro ROTATE_PRIO_EN selects rotating priority. When it is set,
// the last acked index becomes the lowest priority. When it is not set,
// bit 0 is always the highest priority.
module irq_ctrl #(
    parameter int         NUM_IRQ  = 8,
    parameter logic [7:0] MASK_RST = 8'h00
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_IRQ-1:0]         req,
    input  logic                       mask_we,
    input  logic [NUM_IRQ-1:0]         mask_wdata,
    input  logic                       ack,
    input  logic                       eoi,
    output logic                       interrupt,
    output logic [$clog2(NUM_IRQ)-1:0] irq,
    output logic [NUM_IRQ-1:0]         pending,
    output logic                       in_service,
    output logic [NUM_IRQ-1:0]         mask
);

    localparam int IDX_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t                 state_r, state_next_s;
    logic [NUM_IRQ-1:0]     req_q_r;
    logic [NUM_IRQ-1:0]     pending_r, pending_next_s;
    logic [NUM_IRQ-1:0]     mask_r;
    logic                   interrupt_r, interrupt_next_s;
    logic [IDX_W-1:0]       irq_r, irq_next_s;
    logic                   in_service_r, in_service_next_s;
    logic [NUM_IRQ-1:0]     rise_s;
    logic [NUM_IRQ-1:0]     eligible_s;
    logic [NUM_IRQ-1:0]     clr_s;
    logic [IDX_W-1:0]       search_base_s;
    logic [IDX_W:0]         pick_s;
    logic                   sel_found_s;
    logic [IDX_W-1:0]       sel_idx_s;

    // Search the eligible vector starting at base, wrapping around.
    // Returns {found, index}; the first hit in search order wins.
    function automatic logic [IDX_W:0] pick_first(
        input logic [NUM_IRQ-1:0] elig,
        input logic [IDX_W-1:0]   base
    );
        logic             found;
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        sel   = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_IRQ; i++) begin
            idx = base + IDX_W'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    assign rise_s      = req & ~req_q_r;
    assign eligible_s  = pending_r & ~mask_r;
    assign pick_s      = pick_first(eligible_s, search_base_s);
    assign sel_found_s = pick_s[IDX_W];
    assign sel_idx_s   = pick_s[IDX_W-1:0];

`ifdef ROTATE_PRIO_EN
    logic [IDX_W-1:0] last_acked_r, last_acked_next_s;

    assign search_base_s = last_acked_r + {{(IDX_W-1){1'b0}}, 1'b1};

    // Remember the most recently acked index so that it rotates to lowest priority.
    always_comb begin
        last_acked_next_s = last_acked_r;
        if (state_r == ST_REQ && ack) begin
            last_acked_next_s = irq_r;
        end else begin
            last_acked_next_s = last_acked_r;
        end
    end

    // Last-acked register; reset to the top index so the initial order is fixed priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_acked_r <= {IDX_W{1'b1}};
        end else begin
            last_acked_r <= last_acked_next_s;
        end
    end
`else
    assign search_base_s = {IDX_W{1'b0}};
`endif

    // Next state and outputs for the present/take/return handshake.
    always_comb begin
        state_next_s      = state_r;
        interrupt_next_s  = interrupt_r;
        irq_next_s        = irq_r;
        in_service_next_s = in_service_r;
        clr_s             = {NUM_IRQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) begin
                    irq_next_s       = sel_idx_s;
                    interrupt_next_s = 1'b1;
                    state_next_s     = ST_REQ;
                end else begin
                    interrupt_next_s = 1'b0;
                end
            end
            ST_REQ: begin
                // ack has priority over a mask withdrawal in the same cycle
                if (ack) begin
                    clr_s[irq_r]      = 1'b1;
                    interrupt_next_s  = 1'b0;
                    in_service_next_s = 1'b1;
                    state_next_s      = ST_SVC;
                end else if (mask_r[irq_r]) begin
                    interrupt_next_s = 1'b0;
                    state_next_s     = ST_IDLE;
                end else begin
                    interrupt_next_s = 1'b1;
                end
            end
            ST_SVC: begin
                if (eoi) begin
                    in_service_next_s = 1'b0;
                    state_next_s      = ST_IDLE;
                end else begin
                    in_service_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s      = ST_IDLE;
                interrupt_next_s  = 1'b0;
                in_service_next_s = 1'b0;
            end
        endcase
        // a fresh edge on the acked line in the ack cycle keeps it pending
        pending_next_s = (pending_r & ~clr_s) | rise_s;
    end

    // State, presented vector and handshake output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            interrupt_r  <= 1'b0;
            irq_r        <= {IDX_W{1'b0}};
            in_service_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            interrupt_r  <= interrupt_next_s;
            irq_r        <= irq_next_s;
            in_service_r <= in_service_next_s;
        end
    end

    // Request history, pending latch and mask register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q_r   <= {NUM_IRQ{1'b0}};
            pending_r <= {NUM_IRQ{1'b0}};
            mask_r    <= MASK_RST[NUM_IRQ-1:0];
        end else begin
            req_q_r   <= req;
            pending_r <= pending_next_s;
            if (mask_we) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign interrupt  = interrupt_r;
    assign irq        = irq_r;
    assign pending    = pending_r;
    assign in_service = in_service_r;
    assign mask       = mask_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl. A behavioural model predicts the outputs
// after each clock edge and queues them, and a monitor compares them with the DUT.
module tb_irq_ctrl;

    logic       clock;
    logic       reset_n;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic       eoi;
    logic       interrupt;
    logic [2:0] irq;
    logic [7:0] pending;
    logic       in_service;
    logic [7:0] mask;

    irq_ctrl #(.NUM_IRQ(8), .MASK_RST(8'h00)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .eoi        (eoi),
        .interrupt  (interrupt),
        .irq        (irq),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask)
    );

    typedef struct {
        logic       intr;
        logic [2:0] vec;
        logic [7:0] pend;
        logic       svc;
        logic [7:0] msk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    // reference model: what the CPU should observe
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_prev;
    bit         m_presenting;
    bit         m_serving;
    int         m_vec;
    int         m_last;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int model_pick(input logic [7:0] elig, input int last);
        for (int k = 0; k < 8; k++) begin
`ifdef ROTATE_PRIO_EN
            int idx = (last + 1 + k) % 8;
`else
            int idx = k;
`endif
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
        m_presenting = 0; m_serving = 0; m_vec = 0; m_last = 7;
    endtask

    task automatic model_step(input logic [7:0] r, input logic we, input logic [7:0] wd,
                              input logic a, input logic e);
        logic [7:0] rise;
        logic [7:0] taken;
        exp_t x;
        int p;
        rise  = r & ~m_prev;
        taken = 8'h00;
        if (m_serving) begin
            if (e) m_serving = 0;
        end else if (m_presenting) begin
            if (a) begin
                taken[m_vec] = 1'b1;
                m_presenting = 0;
                m_serving    = 1;
                m_last       = m_vec;
            end else if (m_mask[m_vec]) begin
                m_presenting = 0;
            end
        end else begin
            p = model_pick(m_pend & ~m_mask, m_last);
            if (p >= 0) begin
                m_vec = p;
                m_presenting = 1;
            end
        end
        m_pend = (m_pend & ~taken) | rise;
        if (we) m_mask = wd;
        m_prev = r;
        x.intr = m_presenting;
        x.vec  = 3'(m_vec);
        x.pend = m_pend;
        x.svc  = m_serving;
        x.msk  = m_mask;
        exp_q.push_back(x);
        n_push++;
    endtask

    task automatic drive(input logic [7:0] r, input logic we, input logic [7:0] wd,
                         input logic a, input logic e);
        @(negedge clock);
        reset_n = 1'b1; req = r; mask_we = we; mask_wdata = wd; ack = a; eoi = e;
        model_step(r, we, wd, a, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(m_prev, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0; req = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; ack = 1'b0; eoi = 1'b0;
        #1;
        chk("rst_interrupt", {7'h00, interrupt}, 8'h00);
        chk("rst_irq", {5'h00, irq}, 8'h00);
        chk("rst_pending", pending, 8'h00);
        chk("rst_in_service", {7'h00, in_service}, 8'h00);
        chk("rst_mask", mask, 8'h00);
        model_reset();
        exp_q.delete();
    endtask

    // monitor: compare every queued prediction just after the edge it belongs to
    always @(posedge clock) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_pop++;
            chk("interrupt", {7'h00, interrupt}, {7'h00, x.intr});
            chk("irq", {5'h00, irq}, {5'h00, x.vec});
            chk("pending", pending, x.pend);
            chk("in_service", {7'h00, in_service}, {7'h00, x.svc});
            chk("mask", mask, x.msk);
        end
    end

    initial begin
        logic [7:0] r;
        reset_n = 1'b0; req = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; ack = 1'b0; eoi = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        apply_reset();
        idle(2);

        // plan 1: single request, ack, eoi
        drive(8'h04, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        drive(8'h04, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
        drive(8'h04, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);

        // plan 2 and 3: simultaneous 5/1, then req 0 during REQ on 5
        drive(8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        drive(8'h22, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(8'h22, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);
        drive(8'h23, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        drive(8'h23, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);
        drive(8'h23, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);
        drive(8'h23, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);

        // plan 4: masked source stays pending, unmask presents it
        drive(8'h00, 1'b1, 8'h08, 1'b0, 1'b0);
        drive(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(3);
        drive(8'h08, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(3);
        drive(8'h08, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);

        // plan 5: withdrawal by mask, then mask write together with ack
        drive(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        drive(8'h10, 1'b1, 8'h10, 1'b0, 1'b0);
        idle(3);
        drive(8'h10, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(2);
        drive(8'h10, 1'b1, 8'h10, 1'b1, 1'b0);
        idle(2);
        drive(8'h10, 1'b1, 8'h00, 1'b0, 1'b1);
        idle(2);

        // plan 6: reset in the middle of service with more pending
        drive(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        drive(8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(8'hA1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        apply_reset();
        idle(2);

        // rotation scenario: 0 and 1 pending, serve 0, re-raise 0
        drive(8'h03, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        drive(8'h03, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(8'h02, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(8'h03, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(3);
        drive(8'h03, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(8'h03, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic a, e, we;
            logic [7:0] wd;
            r  = m_prev ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            a  = m_presenting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            e  = m_serving    ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 11) == 0);
            wd = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                apply_reset();
            end else begin
                drive(r, we, wd, a, e);
            end
        end
        idle(2);
        @(negedge clock);
        chk("monitor_drained", n_pop[7:0], n_push[7:0]);
        checks++;
        if (n_pop != n_push || exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_count: popped %0d pushed %0d", n_pop, n_push);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
